// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential 4-digit packed BCD to 14-bit binary converter.
// One digit per clock, most significant first, using acc = acc*10 + digit.
//
// Handshake: start is a level request sampled only in IDLE. done is a level
// that stays high in DONE until start is seen low, then the block returns to
// IDLE. value/error are valid while done=1 and hold until the next DONE entry.
module bcd_to_binary (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bcd,
  output logic [13:0] value,
  output logic        done,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // FSM state is kept in a plainly named register so checkers can bind to it.
  logic [1:0]  state;
  logic [15:0] bcd_q;
  logic [16:0] acc;
  logic [1:0]  idx;
  logic        err_q;
  logic [13:0] value_r;
  logic        error_r;

  logic [3:0]  digit;
  logic [16:0] acc_next;
  logic        err_next;
  logic        err_final;

  // Select the digit currently being accumulated.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd3:    digit = bcd_q[15:12];
      2'd2:    digit = bcd_q[11:8];
      2'd1:    digit = bcd_q[7:4];
      default: digit = bcd_q[3:0];
    endcase
  end

  // Multiply-by-10 as two shifts, plus the new digit; error is sticky.
  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + {13'd0, digit};
    err_next  = err_q | (digit > 4'd9);
    // Results above 14 bits can only come from invalid digits, so folding the
    // high accumulator bits in never changes the flag for valid input.
    err_final = err_next | (|acc_next[16:14]);
  end

  // Control FSM and datapath registers; reset has priority everywhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bcd_q   <= 16'd0;
      acc     <= 17'd0;
      idx     <= 2'd0;
      err_q   <= 1'b0;
      value_r <= 14'd0;
      error_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bcd_q <= bcd;
            acc   <= 17'd0;
            err_q <= 1'b0;
            idx   <= 2'd3;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc   <= acc_next;
          err_q <= err_next;
          idx   <= idx - 2'd1;
          if (idx == 2'd0) begin
            value_r <= err_final ? 14'd0 : acc_next[13:0];
            error_r <= err_final;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign value = value_r;
  assign error = error_r;
  assign done  = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: scoreboard bench for bcd_to_binary.
// Expected {error,value} pairs are computed from the stimulus and queued when
// start is driven, then popped and compared when done rises.
module tb_bcd_to_binary;

  // Clock and reset signals
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] value;
  logic        done;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  bcd_to_binary dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .value (value),
    .done  (done),
    .busy  (busy),
    .error (error)
  );

  // Scoreboard state
  logic [14:0] exp_q[$];
  logic [13:0] prev_val;
  logic        prev_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: decimal weighting of each nibble, any nibble >9 flags error.
  function automatic logic [14:0] model(input logic [15:0] b);
    int   v;
    logic e;
    logic [3:0] d;
    v = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = b[i*4 +: 4];
      if (d > 4'd9) e = 1'b1;
      v = v * 10 + int'(d);
    end
    if (e) return {1'b1, 14'd0};
    return {1'b0, v[13:0]};
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] b;
    for (int i = 0; i < 4; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // Driver: one full conversion. Inputs change on the falling edge.
  // hold: DONE cycles with start kept high; chg_edge: edge before which bcd
  // is changed to chg_val (0 = no change).
  task automatic run_conv(input logic [15:0] b, input int hold,
                          input int chg_edge, input logic [15:0] chg_val);
    logic [14:0] exp;
    bcd   = b;
    start = 1'b1;
    exp_q.push_back(model(b));
    @(posedge clk);                       // E0: sampling edge
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check("busy_conv", busy, 1);
      check("done_early", done, 0);
      check("value_hold", value, prev_val);
      check("error_hold", error, prev_err);
      if (chg_edge == e) bcd = chg_val;
    end
    @(negedge clk);                       // after E4
    check("done_latency", done, 1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("value", value, exp[13:0]);
      check("error", error, exp[14]);
      prev_val = exp[13:0];
      prev_err = exp[14];
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_held", done, 1);
      check("value_held", value, prev_val);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_release", done, 0);
    check("busy_release", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Main sequence
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bcd      = 16'd0;
    prev_val = 14'd0;
    prev_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_value", value, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    reset = 1'b0;

    // Basic conversion, start held high in DONE (no restart)
    run_conv(16'h0351, 4, 0, 16'h0);
    // Boundaries
    run_conv(16'h9999, 0, 0, 16'h0);
    run_conv(16'h0000, 0, 0, 16'h0);
    // Invalid digit, then recovery
    run_conv(16'h12A4, 0, 0, 16'h0);
    run_conv(16'h0042, 0, 0, 16'h0);
    // bcd changes before E2 must be ignored
    run_conv(16'h1234, 0, 2, 16'h8888);
    // Release handshake: start dropped one cycle after done, raised next cycle
    run_conv(16'h0777, 1, 0, 16'h0);
    run_conv(16'h0123, 1, 0, 16'h0);

    // Reset sampled at E2 of a conversion
    bcd   = 16'h5678;
    start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    @(negedge clk);                       // after E1
    reset = 1'b1;
    @(negedge clk);                       // after E2
    reset = 1'b0;
    start = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_value", value, 0);
    check("midrst_error", error, 0);
    prev_val = 14'd0;
    prev_err = 1'b0;
    run_conv(16'h5678, 0, 0, 16'h0);

    // start and reset together: reset wins
    reset = 1'b1;
    start = 1'b1;
    bcd   = 16'h4321;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", busy, 0);
    prev_val = 14'd0;
    prev_err = 1'b0;

    // Random valid values
    for (int r = 0; r < 6; r++) run_conv(rand_bcd(), $urandom_range(0, 2), 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
